stream_mux: RTL and testbench

STREAM_MUX -- requirements
Module: stream_mux

---
 rtl/mux_pkg.sv | 15 +
 rtl/rr_arbiter.sv | 31 +++
 rtl/stream_mux.sv | 106 ++++++++++
 tb/tb_stream_mux.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// Shared constants and helpers for the stream multiplexer and its arbiter.
package mux_pkg;

    localparam int MODE_SEL = 0;
    localparam int MODE_RR  = 1;

    // Width of a channel index: clog2(n), but never narrower than one bit.
    function automatic int sel_width(input int n);
        int w;
        w = 0;
        while ((1 << w) < n) w++;
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester after ptr, wrapping modulo N.
module rr_arbiter
    import mux_pkg::*;
#(
    parameter int N  = 4,
    parameter int SW = sel_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [SW-1:0] ptr,
    input  logic          enable,
    output logic [N-1:0]  grant
);

    logic found;

    // NOTE: every variable written in always_comb gets a default first; a
    // path that leaves one unassigned would infer a latch.
    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int k = 1; k <= N; k++) begin
            for (int i = 0; i < N; i++) begin
                if (enable && !found && req[i] && (i == (int'(ptr) + k) % N)) begin
                    grant[i] = 1'b1;
                    found    = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/stream_mux.sv
// N-to-1 valid/ready stream multiplexer with a registered output stage,
// choosing its source by explicit select (MODE_SEL) or round-robin (MODE_RR).
module stream_mux
    import mux_pkg::*;
#(
    parameter  int W    = 32,
    parameter  int N    = 4,
    parameter  int MODE = 0,
    localparam int SW   = sel_width(N)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N*W-1:0]  in_data,
    input  logic [N-1:0]    in_valid,
    output logic [N-1:0]    in_ready,
    input  logic [SW-1:0]   sel,
    output logic [W-1:0]    out_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [SW-1:0]   out_chan
);

    logic [N-1:0]  grant;
    logic          load;
    logic          accept;
    logic [W-1:0]  acc_data;
    logic [SW-1:0] acc_idx;

    logic          out_valid_q, out_valid_d;
    logic [W-1:0]  out_data_q,  out_data_d;
    logic [SW-1:0] out_chan_q,  out_chan_d;

    // Grants are forced off while rst_n is low so no upstream beat is consumed.
    if (MODE == MODE_RR) begin : g_rr
        logic [SW-1:0] ptr_q, ptr_d;

        rr_arbiter #(.N(N), .SW(SW)) u_arb (
            .req    (in_valid),
            .ptr    (ptr_q),
            .enable (rst_n),
            .grant  (grant)
        );

        assign ptr_d = accept ? acc_idx : ptr_q;

        // NOTE: sequential state uses non-blocking assignments only, so every
        // register samples the pre-edge value of its inputs.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) ptr_q <= SW'(N - 1);
            else        ptr_q <= ptr_d;
        end
    end else begin : g_sel
        always_comb begin
            grant = '0;
            for (int i = 0; i < N; i++) begin
                if (rst_n && in_valid[i] && (int'(sel) == i)) grant[i] = 1'b1;
            end
        end
    end

    assign load     = !out_valid_q || out_ready;
    assign in_ready = load ? grant : '0;
    assign accept   = |in_ready;

    always_comb begin
        acc_data = '0;
        acc_idx  = '0;
        for (int i = 0; i < N; i++) begin
            if (in_ready[i]) begin
                acc_data = in_data[i*W +: W];
                acc_idx  = SW'(i);
            end
        end
    end

    // A grant on a drain cycle replaces the held beat directly, so there is no bubble.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_chan_d  = out_chan_q;
        if (accept) begin
            out_valid_d = 1'b1;
            out_data_d  = acc_data;
            out_chan_d  = acc_idx;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_chan_q  <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_chan_q  <= out_chan_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_chan  = out_chan_q;

endmodule

// File: tb/tb_stream_mux.sv
// Directed bench: one explicit-select and one round-robin instance, N=4, W=32.
module tb_stream_mux;

    localparam int W  = 32;
    localparam int N  = 4;
    localparam int SW = 2;

    logic clk;
    logic rst_n;

    logic [N*W-1:0] s_data;
    logic [N-1:0]   s_valid, s_ready;
    logic [SW-1:0]  s_sel;
    logic [W-1:0]   s_odata;
    logic           s_ovalid, s_oready;
    logic [SW-1:0]  s_ochan;

    logic [N*W-1:0] r_data;
    logic [N-1:0]   r_valid, r_ready;
    logic [SW-1:0]  r_sel;
    logic [W-1:0]   r_odata;
    logic           r_ovalid, r_oready;
    logic [SW-1:0]  r_ochan;

    int tests = 0;
    int fails = 0;

    stream_mux #(.W(W), .N(N), .MODE(0)) u_sel (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (s_data),
        .in_valid  (s_valid),
        .in_ready  (s_ready),
        .sel       (s_sel),
        .out_data  (s_odata),
        .out_valid (s_ovalid),
        .out_ready (s_oready),
        .out_chan  (s_ochan)
    );

    stream_mux #(.W(W), .N(N), .MODE(1)) u_rr (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (r_data),
        .in_valid  (r_valid),
        .in_ready  (r_ready),
        .sel       (r_sel),
        .out_data  (r_odata),
        .out_valid (r_ovalid),
        .out_ready (r_oready),
        .out_chan  (r_ochan)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n    = 1'b0;
        s_data   = '0;
        s_valid  = '0;
        s_sel    = '0;
        s_oready = 1'b0;
        r_valid  = '0;
        r_sel    = '0;
        r_oready = 1'b0;
        for (int i = 0; i < N; i++) r_data[i*W +: W] = 32'hA0 + i;

        // Reset state
        #12;
        check("rst s_out_valid", 64'(s_ovalid), 64'd0);
        check("rst s_out_data",  64'(s_odata),  64'd0);
        check("rst s_out_chan",  64'(s_ochan),  64'd0);
        check("rst r_out_valid", 64'(r_ovalid), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Explicit select: sel=2, channel 2 valid
        s_sel    = 2'd2;
        s_valid  = 4'b0100;
        s_data   = {32'h0000_0004, 32'hDEAD_BEEF, 32'h0000_0002, 32'h0000_0001};
        s_oready = 1'b1;
        #1;
        check("sel2 in_ready", 64'(s_ready), 64'b0100);
        step();
        check("sel2 out_valid", 64'(s_ovalid), 64'd1);
        check("sel2 out_data",  64'(s_odata),  64'hDEAD_BEEF);
        check("sel2 out_chan",  64'(s_ochan),  64'd2);
        s_valid = 4'b0000;
        #1;
        check("idle in_ready", 64'(s_ready), 64'd0);
        step();
        check("drain out_valid", 64'(s_ovalid), 64'd0);
        check("drain out_data hold", 64'(s_odata), 64'hDEAD_BEEF);

        // Selected channel not valid: no grant
        s_sel   = 2'd3;
        s_valid = 4'b0111;
        #1;
        check("sel3 in_ready", 64'(s_ready), 64'd0);
        step();
        check("sel3 out_valid", 64'(s_ovalid), 64'd0);
        check("sel3 out_chan hold", 64'(s_ochan), 64'd2);

        // Backpressure: hold 0x11 while out_ready is low
        s_sel    = 2'd0;
        s_valid  = 4'b0001;
        s_data   = {32'h4, 32'h3, 32'h2, 32'h11};
        s_oready = 1'b0;
        #1;
        check("bp load in_ready", 64'(s_ready), 64'b0001);
        step();
        check("bp out_valid", 64'(s_ovalid), 64'd1);
        check("bp out_data",  64'(s_odata),  64'h11);
        s_data[W-1:0] = 32'h22;
        for (int c = 0; c < 3; c++) begin
            #1;
            check($sformatf("bp stall%0d in_ready", c), 64'(s_ready), 64'd0);
            check($sformatf("bp stall%0d out_data", c), 64'(s_odata), 64'h11);
            step();
        end
        s_oready = 1'b1;
        #1;
        check("bp release in_ready", 64'(s_ready), 64'b0001);
        step();
        check("bp next out_data",  64'(s_odata),  64'h22);
        check("bp next out_valid", 64'(s_ovalid), 64'd1);
        s_valid = 4'b0000;

        // Round-robin: all valid, 8 beats back to back from channel 0
        r_valid  = 4'b1111;
        r_oready = 1'b1;
        #1;
        check("rr first in_ready", 64'(r_ready), 64'b0001);
        for (int k = 0; k < 8; k++) begin
            step();
            check($sformatf("rr beat%0d out_chan", k),  64'(r_ochan),  64'(k % 4));
            check($sformatf("rr beat%0d out_valid", k), 64'(r_ovalid), 64'd1);
        end

        // Set ptr=0, then alternate between channels 3 and 0
        r_valid = 4'b0001;
        step();
        check("rr ptr0 out_chan", 64'(r_ochan), 64'd0);
        r_valid = 4'b1001;
        #1;
        check("rr wrap in_ready", 64'(r_ready), 64'b1000);
        step();
        check("rr wrap1 out_chan", 64'(r_ochan), 64'd3);
        step();
        check("rr wrap2 out_chan", 64'(r_ochan), 64'd0);
        step();
        check("rr wrap3 out_chan", 64'(r_ochan), 64'd3);
        check("rr wrap3 out_data", 64'(r_odata), 64'hA3);

        // Asynchronous reset while a beat is held
        r_valid  = 4'b0000;
        r_oready = 1'b0;
        step();
        check("pre-rst out_valid", 64'(r_ovalid), 64'd1);
        #2;
        rst_n   = 1'b0;
        r_valid = 4'b0110;
        #1;
        check("async rst out_valid", 64'(r_ovalid), 64'd0);
        check("async rst out_data",  64'(r_odata),  64'd0);
        check("async rst out_chan",  64'(r_ochan),  64'd0);
        check("async rst in_ready",  64'(r_ready),  64'd0);
        @(negedge clk);
        rst_n    = 1'b1;
        r_oready = 1'b1;
        #1;
        check("post-rst in_ready", 64'(r_ready), 64'b0010);
        step();
        check("post-rst out_chan", 64'(r_ochan), 64'd1);
        check("post-rst out_data", 64'(r_odata), 64'hA1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
